// File: rtl/tx_framer_pkg.sv
// Symbol codes shared by the lane-link transmit framer and the receive-side demux bench.
package tx_framer_pkg;

  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_COM = 8'hBC;

  // DLLPs open with SDP, TLPs with STP.
  function automatic logic [7:0] start_symbol(input logic dllp);
    return dllp ? SYM_SDP : SYM_STP;
  endfunction

endpackage

// File: rtl/tx_framer_skp_timer.sv
// Counts emitted symbols and holds a SKP ordered-set request once SKP_INTERVAL is reached.
module skp_timer #(
  parameter int SKP_INTERVAL = 32
) (
  input  logic clk,
  input  logic reset_L,
  input  logic sym_en,
  input  logic clear,
  output logic req
);

  localparam int CW = $clog2(SKP_INTERVAL + 1);

  logic [CW-1:0] r_count;

  // The count saturates at the interval so the request stays up until serviced.
  assign req = (r_count == CW'(SKP_INTERVAL));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (sym_en && !req) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/tx_framer.sv
// Transmit symbol framer: COM training, STP/SDP-payload-END framing, IDL fill, EDB abort, SKP insertion.
module tx_framer
  import tx_framer_pkg::*;
#(
  parameter int SKP_INTERVAL = 32,
  parameter int NUM_COM      = 4,
  parameter int SKP_LEN      = 3
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_data,
  input  logic       pkt_last,
  input  logic       pkt_dllp,
  output logic       pkt_ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       control,
  output logic       underrun
);

  localparam logic [2:0] ST_INIT_COM = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_START    = 3'd2;
  localparam logic [2:0] ST_PAYLOAD  = 3'd3;
  localparam logic [2:0] ST_END_SYM  = 3'd4;
  localparam logic [2:0] ST_DRAIN    = 3'd5;
  localparam logic [2:0] ST_SKP_SET  = 3'd6;

  // One counter serves both the training COMs and the SKP ordered set.
  localparam int CNT_MAX = (NUM_COM > SKP_LEN + 1) ? NUM_COM : SKP_LEN + 1;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [7:0]       r_data;
  logic             r_control;
  logic             r_ready;
  logic             r_underrun;

  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] w_cnt_next;
  logic [7:0]       w_data;
  logic             w_control;
  logic             w_ready;
  logic             w_underrun_set;
  logic             w_skp_clear;
  logic             w_skp_req;

  skp_timer #(
    .SKP_INTERVAL (SKP_INTERVAL)
  ) u_skp_timer (
    .clk     (clk),
    .reset_L (reset_L),
    .sym_en  (1'b1),
    .clear   (w_skp_clear),
    .req     (w_skp_req)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_cnt_next     = r_cnt;
    w_data         = SYM_IDL;
    w_control      = 1'b1;
    w_ready        = 1'b0;
    w_underrun_set = 1'b0;
    w_skp_clear    = 1'b0;
    case (r_state)
      ST_INIT_COM: begin
        w_data = SYM_COM;
        if (r_cnt == CNT_W'(NUM_COM - 1)) begin
          w_next_state = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (w_skp_req)      w_next_state = ST_SKP_SET;
        else if (pkt_valid) w_next_state = ST_START;
      end
      ST_START: begin
        w_data       = start_symbol(pkt_dllp);
        w_next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        w_ready = 1'b1;
        if (pkt_valid) begin
          w_data    = pkt_data;
          w_control = 1'b0;
          if (pkt_last) w_next_state = ST_END_SYM;
        end else begin
          // Source starved mid-packet: abort it and swallow the remainder.
          w_data         = SYM_EDB;
          w_underrun_set = 1'b1;
          w_next_state   = ST_DRAIN;
        end
      end
      ST_END_SYM: begin
        w_data = SYM_END;
        if (w_skp_req)      w_next_state = ST_SKP_SET;
        else if (pkt_valid) w_next_state = ST_START;
        else                w_next_state = ST_IDLE;
      end
      ST_DRAIN: begin
        w_ready = 1'b1;
        if (pkt_valid && pkt_last) w_next_state = ST_IDLE;
      end
      ST_SKP_SET: begin
        if (r_cnt == '0) begin
          w_data      = SYM_COM;
          w_skp_clear = 1'b1;
        end else begin
          w_data = SYM_SKP;
        end
        if (r_cnt == CNT_W'(SKP_LEN)) begin
          w_next_state = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_INIT_COM;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_data     <= 8'h00;
      r_control  <= 1'b0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_cnt_next;
      r_valid    <= 1'b1;
      r_data     <= w_data;
      r_control  <= w_control;
      r_ready    <= w_ready;
      r_underrun <= r_underrun | w_underrun_set;
    end
  end

  assign valid     = r_valid;
  assign data      = r_data;
  assign control   = r_control;
  assign pkt_ready = r_ready;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: training set, framing, back-to-back, SKP insertion, underrun, reset.
module tb_tx_framer;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       pkt_valid;
  logic [7:0] pkt_data;
  logic       pkt_last;
  logic       pkt_dllp;
  logic       pkt_ready;
  logic       valid;
  logic [7:0] data;
  logic       control;
  logic       underrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] src_data[$];
  logic       src_last[$];
  logic       src_dllp[$];
  logic       stall;

  logic [7:0] cap_data[$];
  logic       cap_ctrl[$];
  logic       cap_valid[$];
  logic       cap_rdy[$];
  logic       cap_und[$];

  tx_framer #(
    .SKP_INTERVAL (32),
    .NUM_COM      (4),
    .SKP_LEN      (3)
  ) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .pkt_valid (pkt_valid),
    .pkt_data  (pkt_data),
    .pkt_last  (pkt_last),
    .pkt_dllp  (pkt_dllp),
    .pkt_ready (pkt_ready),
    .valid     (valid),
    .data      (data),
    .control   (control),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic apply_inputs();
    if (src_data.size() > 0 && !stall) begin
      pkt_valid = 1'b1;
      pkt_data  = src_data[0];
      pkt_last  = src_last[0];
      pkt_dllp  = src_dllp[0];
    end else begin
      pkt_valid = 1'b0;
      pkt_data  = 8'h00;
      pkt_last  = 1'b0;
      pkt_dllp  = 1'b0;
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last, input logic dllp);
    src_data.push_back(d);
    src_last.push_back(last);
    src_dllp.push_back(dllp);
  endtask

  task automatic clear_all();
    src_data.delete(); src_last.delete(); src_dllp.delete();
    cap_data.delete(); cap_ctrl.delete(); cap_valid.delete();
    cap_rdy.delete();  cap_und.delete();
    stall = 1'b0;
  endtask

  // One symbol clock; a byte counts as taken when it was offered and pkt_ready rose with it.
  task automatic tick();
    logic drove;
    drove = pkt_valid;
    @(posedge clk);
    #1;
    cap_data.push_back(data);
    cap_ctrl.push_back(control);
    cap_valid.push_back(valid);
    cap_rdy.push_back(pkt_ready);
    cap_und.push_back(underrun);
    if (pkt_ready && drove && src_data.size() > 0) begin
      void'(src_data.pop_front());
      void'(src_last.pop_front());
      void'(src_dllp.pop_front());
    end
    apply_inputs();
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    clear_all();
    apply_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    clear_all();
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (valid !== 1'b0)     begin failures++; $display("FAIL rst_valid: got %b expected 0", valid); end
    if (data !== 8'h00)     begin failures++; $display("FAIL rst_data: got %02h expected 00", data); end
    if (control !== 1'b0)   begin failures++; $display("FAIL rst_control: got %b expected 0", control); end
    if (pkt_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", pkt_ready); end
    if (underrun !== 1'b0)  begin failures++; $display("FAIL rst_underrun: got %b expected 0", underrun); end
    @(negedge clk);
    reset_L = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      e = (i < 4) ? 8'hBC : 8'h7C;
      checks++;
      if (cap_data[i] !== e || cap_ctrl[i] !== 1'b1 || cap_valid[i] !== 1'b1) begin
        failures++;
        $display("FAIL train[%0d]: got data=%02h ctrl=%b valid=%b expected data=%02h ctrl=1 valid=1",
                 i, cap_data[i], cap_ctrl[i], cap_valid[i], e);
      end
    end
  endtask

  task automatic test_packet();
    logic [7:0] exp_d[$];
    logic       exp_c[$];
    logic       exp_r[$];
    do_reset();
    repeat (4) tick();
    push_byte(8'h01, 1'b0, 1'b0);
    push_byte(8'h02, 1'b1, 1'b0);
    apply_inputs();
    cap_data.delete(); cap_ctrl.delete(); cap_rdy.delete();
    repeat (5) tick();
    exp_d = {8'h7C, 8'hFB, 8'h01, 8'h02, 8'hFD};
    exp_c = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_r = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_ctrl[i] !== exp_c[i] || cap_rdy[i] !== exp_r[i]) begin
        failures++;
        $display("FAIL packet[%0d]: got data=%02h ctrl=%b ready=%b expected data=%02h ctrl=%b ready=%b",
                 i, cap_data[i], cap_ctrl[i], cap_rdy[i], exp_d[i], exp_c[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d[$];
    logic       exp_c[$];
    do_reset();
    repeat (4) tick();
    for (int b = 3; b <= 12; b++) push_byte(8'(b), (b == 12), 1'b0);
    push_byte(8'h0D, 1'b0, 1'b1);
    push_byte(8'h0E, 1'b1, 1'b1);
    apply_inputs();
    cap_data.delete(); cap_ctrl.delete();
    repeat (17) tick();
    exp_d = {8'h7C, 8'hFB};
    exp_c = {1'b1, 1'b1};
    for (int b = 3; b <= 12; b++) begin exp_d.push_back(8'(b)); exp_c.push_back(1'b0); end
    exp_d = {exp_d, 8'hFD, 8'h5C, 8'h0D, 8'h0E, 8'hFD};
    exp_c = {exp_c, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_ctrl[i] !== exp_c[i]) begin
        failures++;
        $display("FAIL b2b[%0d]: got data=%02h ctrl=%b expected data=%02h ctrl=%b",
                 i, cap_data[i], cap_ctrl[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  // Packet straddles the 32-symbol SKP point; a second packet is already waiting at END.
  task automatic test_skp();
    logic [7:0] exp_d[$];
    logic       exp_c[$];
    do_reset();
    repeat (27) tick();
    for (int b = 0; b < 8; b++) push_byte(8'h10 + 8'(b), (b == 7), 1'b0);
    push_byte(8'hAA, 1'b1, 1'b0);
    apply_inputs();
    cap_data.delete(); cap_ctrl.delete();
    repeat (19) tick();
    exp_d = {8'h7C, 8'hFB};
    exp_c = {1'b1, 1'b1};
    for (int b = 0; b < 8; b++) begin exp_d.push_back(8'h10 + 8'(b)); exp_c.push_back(1'b0); end
    exp_d = {exp_d, 8'hFD, 8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h7C, 8'hFB, 8'hAA, 8'hFD};
    exp_c = {exp_c, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 19; i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_ctrl[i] !== exp_c[i]) begin
        failures++;
        $display("FAIL skp[%0d]: got data=%02h ctrl=%b expected data=%02h ctrl=%b",
                 i, cap_data[i], cap_ctrl[i], exp_d[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_underrun();
    logic [7:0] exp_d[$];
    logic       exp_r[$];
    logic       exp_u[$];
    do_reset();
    repeat (4) tick();
    for (int b = 0; b < 5; b++) push_byte(8'h21 + 8'(b), (b == 4), 1'b0);
    apply_inputs();
    cap_data.delete(); cap_rdy.delete(); cap_und.delete();
    repeat (4) tick();
    stall = 1'b1;
    apply_inputs();
    tick();
    stall = 1'b0;
    apply_inputs();
    repeat (3) tick();
    push_byte(8'h31, 1'b1, 1'b0);
    apply_inputs();
    repeat (4) tick();
    exp_d = {8'h7C, 8'hFB, 8'h21, 8'h22, 8'hFE, 8'h7C, 8'h7C, 8'h7C, 8'h7C, 8'hFB, 8'h31, 8'hFD};
    exp_r = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_u = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (cap_data[i] !== exp_d[i] || cap_rdy[i] !== exp_r[i] || cap_und[i] !== exp_u[i]) begin
        failures++;
        $display("FAIL underrun[%0d]: got data=%02h ready=%b underrun=%b expected data=%02h ready=%b underrun=%b",
                 i, cap_data[i], cap_rdy[i], cap_und[i], exp_d[i], exp_r[i], exp_u[i]);
      end
    end
  endtask

  // Runs straight after test_underrun so underrun is still set going in.
  task automatic test_reset_mid_packet();
    for (int b = 0; b < 5; b++) push_byte(8'h41 + 8'(b), (b == 4), 1'b0);
    apply_inputs();
    cap_data.delete();
    repeat (4) tick();
    checks++;
    if (cap_data[3] !== 8'h42 || underrun !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got data=%02h underrun=%b expected data=42 underrun=1", cap_data[3], underrun);
    end
    #2;
    reset_L = 1'b0;
    #1;
    checks += 5;
    if (valid !== 1'b0)     begin failures++; $display("FAIL mid_rst_valid: got %b expected 0", valid); end
    if (data !== 8'h00)     begin failures++; $display("FAIL mid_rst_data: got %02h expected 00", data); end
    if (control !== 1'b0)   begin failures++; $display("FAIL mid_rst_control: got %b expected 0", control); end
    if (pkt_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %b expected 0", pkt_ready); end
    if (underrun !== 1'b0)  begin failures++; $display("FAIL mid_rst_underrun: got %b expected 0", underrun); end
    clear_all();
    apply_inputs();
    @(negedge clk);
    reset_L = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] e;
      e = (i < 4) ? 8'hBC : 8'h7C;
      checks++;
      if (cap_data[i] !== e || cap_ctrl[i] !== 1'b1 || cap_valid[i] !== 1'b1) begin
        failures++;
        $display("FAIL retrain[%0d]: got data=%02h ctrl=%b valid=%b expected data=%02h ctrl=1 valid=1",
                 i, cap_data[i], cap_ctrl[i], cap_valid[i], e);
      end
    end
  endtask

  initial begin
    reset_L   = 1'b0;
    pkt_valid = 1'b0;
    pkt_data  = 8'h00;
    pkt_last  = 1'b0;
    pkt_dllp  = 1'b0;
    stall     = 1'b0;
    test_reset();
    test_packet();
    test_back_to_back();
    test_skp();
    test_underrun();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
